hd44780_bus_monitor: RTL and testbench
======================================

// Module: hd44780_bus_monitor
// PURPOSE
//  Passive decoder for the PCF8574 -> HD44780 4-bit LCD bus: consumes each port byte written to the expander,
//  detects EN falling edges, reassembles nibbles into instruction/data bytes and models the DDRAM address.
//  Sits behind the I2C slave model (sim) or a bus sniffer (HW debug); gives self-checking visibility of LCD traffic.
// PARAMETERS
//  CLK_HZ        1_000_000  clock frequency; scales execution-time counters
//  EXEC_US_SHORT 37         execution time (us) of ordinary instructions and data writes
//  EXEC_US_LONG  1520       execution time (us) of clear (0x01) and return-home (0x02/0x03)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  port_valid   in   1  one-cycle strobe: port_byte is a new expander output value
//  port_byte    in   8  {D7,D6,D5,D4,BL,EN,RW,RS}
//  out_valid    out  1  one-cycle pulse: out_byte/out_rs hold a completed LCD transfer
//  out_rs       out  1  0 = instruction, 1 = data
//  out_byte     out  8  completed byte (8-bit mode: {nibble,4'h0})
//  mode4        out  1  1 = interface in 4-bit mode
//  ddram_addr   out  7  modelled address counter after the transfer
//  backlight    out  1  BL bit of the last port byte
//  rd_err       out  1  one-cycle pulse: EN fall with RW=1 (read unsupported; strobe dropped)
//  timing_err   out  1  one-cycle pulse: strobe while previous transfer still executing (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, mode4=0 (8-bit boot mode), phase=HI, prev_en=0, I/D=increment, cgram_sel=0, exec_cnt=0.
//  Strobe = port_valid with prev_en=1 and port_byte[2]=0; nibble and RS taken from that byte. prev_en updates on every
//   port_valid; backlight <= port_byte[3] on every port_valid. Back-to-back port_valid every cycle is legal.
//  Strobe with RW=1: rd_err pulse, no nibble consumed, phase unchanged.
//  Mode FSM: BOOT8 -> each strobe completes {nibble,4'h0}. FOUR_HI -> latch nibble, go FOUR_LO. FOUR_LO -> complete
//   {hi,lo}, go FOUR_HI. RS change between HI and LO: completed byte uses RS of the LO strobe.
//  Completed instruction with byte[7:5]=3'b001 (function set): DL=byte[4]; DL=0 -> mode4=1, phase=HI; DL=1 -> mode4=0.
//   Mode change takes effect from the next strobe. Power-up 0x02 sent as nibbles 0x0,0x2 therefore decodes as
//   out_byte 0x00 then 0x20, entering 4-bit mode; 0x00 is still reported.
//  Latency: out_valid asserted the cycle after the completing port_valid; ddram_addr valid in the same cycle.
//  Address model (instructions): 0x01 -> addr=0, I/D=inc; 0x02/0x03 -> addr=0; 0b000001xx -> I/D=byte[1];
//   0b1xxxxxxx -> addr=byte[6:0], cgram_sel=0; 0b01xxxxxx -> cgram_sel=1, addr unchanged.
//  Data write with cgram_sel=0: inc 0x27->0x40, 0x67->0x00, else +1; dec 0x00->0x67, 0x40->0x27, else -1.
//   Data write with cgram_sel=1: addr unchanged.
//  Reset mid-operation: any partial HI nibble discarded; monitor returns to BOOT8 regardless of prior mode.
// CONFIGURATION
//  HD44780_TIMING_CHECK_EN defined: exec_cnt loaded on each completed byte with EXEC_US_LONG*CLK_HZ/1e6 (clear/home)
//   or EXEC_US_SHORT*CLK_HZ/1e6 (else), decrements to 0 each cycle; any strobe (incl. HI nibble) while exec_cnt!=0
//   pulses timing_err; the strobe is still decoded. Undefined: no counter; timing_err tied 0.
// STRUCTURE
//  Package hd44780_pkg: port bit indices, instruction opcodes/masks (CLEAR, HOME, ENTRY, FUNC_SET, SET_DDRAM,
//   SET_CGRAM), line address limits 0x27/0x40/0x67, mode enum {BOOT8,FOUR_HI,FOUR_LO}.
//  Sub-module hd44780_addr_model: instruction/data byte in, ddram_addr/I/D/cgram_sel state out.
// TESTING
//  1 Init stream (nibbles of 0x02,0x28,0x0C,0x06,0x01, EN 1->0 per nibble) -> out_byte 0x00,0x20,0x28,0x0C,0x06,0x01;
//    mode4=1 after 0x20; ddram_addr=0 after 0x01.
//  2 After init: 0x80 then data 'H','i' (RS=1) -> out_rs=1 bytes 0x48,0x69; ddram_addr 0x01 then 0x02.
//  3 Set 0xA7 (addr 0x27), write 1 data byte -> ddram_addr=0x40; entry 0x04 at addr 0x00, write -> 0x67.
//  4 EN fall with RW=1 in FOUR_LO -> rd_err pulse, no out_valid; next normal LO strobe completes byte correctly.
//  5 With HD44780_TIMING_CHECK_EN, CLK_HZ=1e6: 0x01 then next HI strobe after 1000 cycles -> timing_err=1;
//    after 1600 cycles -> 0; ordinary cmd retried at 30 cycles -> 1, at 40 -> 0.
//  6 rst asserted after a HI nibble in 4-bit mode -> outputs 0, mode4=0; next strobe nibble 0x3 -> out_byte 0x30.

Source files
------------

// File: rtl/hd44780_pkg.sv
// rtl/hd44780_pkg.sv - shared constants, opcodes and mode enum for the HD44780 bus monitor
package hd44780_pkg;

  // Expander port bit positions: {D7,D6,D5,D4,BL,EN,RW,RS}
  localparam int BIT_RS = 0;
  localparam int BIT_RW = 1;
  localparam int BIT_EN = 2;
  localparam int BIT_BL = 3;

  localparam logic [7:0] OP_CLEAR       = 8'h01;
  localparam logic [7:0] OP_HOME        = 8'h02;
  localparam logic [7:0] MASK_HOME      = 8'hFE;
  localparam logic [7:0] OP_ENTRY       = 8'h04;
  localparam logic [7:0] MASK_ENTRY     = 8'hFC;
  localparam logic [7:0] OP_FUNC_SET    = 8'h20;
  localparam logic [7:0] MASK_FUNC_SET  = 8'hE0;
  localparam logic [7:0] OP_SET_DDRAM   = 8'h80;
  localparam logic [7:0] MASK_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM   = 8'h40;
  localparam logic [7:0] MASK_SET_CGRAM = 8'hC0;

  localparam logic [6:0] LINE1_END   = 7'h27;
  localparam logic [6:0] LINE2_START = 7'h40;
  localparam logic [6:0] LINE2_END   = 7'h67;

  typedef enum logic [1:0] {
    BOOT8   = 2'd0,
    FOUR_HI = 2'd1,
    FOUR_LO = 2'd2
  } mode_e;

  function automatic logic is_op(input logic [7:0] b, input logic [7:0] op, input logic [7:0] mask);
    return (b & mask) == op;
  endfunction

  // Clear and return-home are the slow instructions.
  function automatic logic is_long_exec(input logic [7:0] b);
    return (b == OP_CLEAR) || is_op(b, OP_HOME, MASK_HOME);
  endfunction

endpackage

// File: rtl/hd44780_addr_model.sv
// rtl/hd44780_addr_model.sv - DDRAM address counter, entry direction and CGRAM select model
module hd44780_addr_model
  import hd44780_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_byte,
  output logic [6:0] ddram_addr,
  output logic       id_inc,
  output logic       cgram_sel
);

  logic [6:0] addr_step;

  // Two-line display: the counter skips the gap between line ends and line starts.
  always_comb begin
    addr_step = ddram_addr;
    if (id_inc) begin
      if (ddram_addr == LINE1_END)      addr_step = LINE2_START;
      else if (ddram_addr == LINE2_END) addr_step = 7'h00;
      else                              addr_step = ddram_addr + 7'd1;
    end else begin
      if (ddram_addr == 7'h00)             addr_step = LINE2_END;
      else if (ddram_addr == LINE2_START)  addr_step = LINE1_END;
      else                                 addr_step = ddram_addr - 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddram_addr <= 7'h00;
      id_inc     <= 1'b1;
      cgram_sel  <= 1'b0;
    end else if (wr_valid) begin
      if (wr_rs) begin
        if (!cgram_sel) ddram_addr <= addr_step;
      end else if (wr_byte == OP_CLEAR) begin
        ddram_addr <= 7'h00;
        id_inc     <= 1'b1;
      end else if (is_op(wr_byte, OP_HOME, MASK_HOME)) begin
        ddram_addr <= 7'h00;
      end else if (is_op(wr_byte, OP_ENTRY, MASK_ENTRY)) begin
        id_inc <= wr_byte[1];
      end else if (is_op(wr_byte, OP_SET_DDRAM, MASK_SET_DDRAM)) begin
        ddram_addr <= wr_byte[6:0];
        cgram_sel  <= 1'b0;
      end else if (is_op(wr_byte, OP_SET_CGRAM, MASK_SET_CGRAM)) begin
        cgram_sel <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hd44780_bus_monitor.sv
// rtl/hd44780_bus_monitor.sv - passive PCF8574->HD44780 4-bit bus decoder; HD44780_TIMING_CHECK_EN adds busy checking
module hd44780_bus_monitor
  import hd44780_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 1_000_000,
  parameter int unsigned EXEC_US_SHORT = 37,
  parameter int unsigned EXEC_US_LONG  = 1520
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       port_valid,
  input  logic [7:0] port_byte,
  output logic       out_valid,
  output logic       out_rs,
  output logic [7:0] out_byte,
  output logic       mode4,
  output logic [6:0] ddram_addr,
  output logic       backlight,
  output logic       rd_err,
  output logic       timing_err
);

  mode_e       mode_q, mode_d;
  logic        prev_en;
  logic [3:0]  hi_nib;
  logic [3:0]  nib;
  logic        strobe, strobe_rd, strobe_wr;
  logic        complete, latch_hi;
  logic [7:0]  cmp_byte;
  logic        id_inc, cgram_sel;

  assign nib       = port_byte[7:4];
  assign strobe    = port_valid & prev_en & ~port_byte[BIT_EN];
  assign strobe_rd = strobe & port_byte[BIT_RW];
  assign strobe_wr = strobe & ~port_byte[BIT_RW];
  assign mode4     = (mode_q != BOOT8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= BOOT8;
    else     mode_q <= mode_d;
  end

  // Function set overrides the nibble-phase advance; the new width applies from the next strobe.
  always_comb begin
    mode_d = mode_q;
    if (strobe_wr) begin
      case (mode_q)
        BOOT8:   mode_d = BOOT8;
        FOUR_HI: mode_d = FOUR_LO;
        FOUR_LO: mode_d = FOUR_HI;
        default: mode_d = BOOT8;
      endcase
    end
    if (complete && !port_byte[BIT_RS] && is_op(cmp_byte, OP_FUNC_SET, MASK_FUNC_SET))
      mode_d = cmp_byte[4] ? BOOT8 : FOUR_HI;
  end

  always_comb begin
    complete = 1'b0;
    latch_hi = 1'b0;
    cmp_byte = {nib, 4'h0};
    if (strobe_wr) begin
      case (mode_q)
        BOOT8:   complete = 1'b1;
        FOUR_HI: latch_hi = 1'b1;
        FOUR_LO: begin
          complete = 1'b1;
          cmp_byte = {hi_nib, nib};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_en   <= 1'b0;
      hi_nib    <= 4'h0;
      out_valid <= 1'b0;
      out_rs    <= 1'b0;
      out_byte  <= 8'h00;
      backlight <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      out_valid <= complete;
      rd_err    <= strobe_rd;
      if (port_valid) begin
        prev_en   <= port_byte[BIT_EN];
        backlight <= port_byte[BIT_BL];
      end
      if (latch_hi) hi_nib <= nib;
      if (complete) begin
        out_rs   <= port_byte[BIT_RS];
        out_byte <= cmp_byte;
      end
    end
  end

  hd44780_addr_model u_addr_model (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (complete),
    .wr_rs      (port_byte[BIT_RS]),
    .wr_byte    (cmp_byte),
    .ddram_addr (ddram_addr),
    .id_inc     (id_inc),
    .cgram_sel  (cgram_sel)
  );

  logic unused_state;
  assign unused_state = id_inc ^ cgram_sel;

`ifdef HD44780_TIMING_CHECK_EN
  localparam logic [31:0] SHORT_CYC = 32'((64'(EXEC_US_SHORT) * 64'(CLK_HZ)) / 64'd1_000_000);
  localparam logic [31:0] LONG_CYC  = 32'((64'(EXEC_US_LONG) * 64'(CLK_HZ)) / 64'd1_000_000);

  logic [31:0] exec_cnt;

  // A strobe that arrives while busy is flagged but still decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_cnt   <= 32'd0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= strobe && (exec_cnt != 32'd0);
      if (complete)
        exec_cnt <= (!port_byte[BIT_RS] && is_long_exec(cmp_byte)) ? LONG_CYC : SHORT_CYC;
      else if (exec_cnt != 32'd0)
        exec_cnt <= exec_cnt - 32'd1;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = CLK_HZ ^ EXEC_US_SHORT ^ EXEC_US_LONG;
  assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_hd44780_bus_monitor.sv
// tb/tb_hd44780_bus_monitor.sv - randomized self-checking bench for hd44780_bus_monitor
module tb_hd44780_bus_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       port_valid;
  logic [7:0] port_byte;
  logic       out_valid, out_rs, mode4, backlight, rd_err, timing_err;
  logic [7:0] out_byte;
  logic [6:0] ddram_addr;

  hd44780_bus_monitor #(
    .CLK_HZ        (1_000_000),
    .EXEC_US_SHORT (37),
    .EXEC_US_LONG  (1520)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .port_valid (port_valid),
    .port_byte  (port_byte),
    .out_valid  (out_valid),
    .out_rs     (out_rs),
    .out_byte   (out_byte),
    .mode4      (mode4),
    .ddram_addr (ddram_addr),
    .backlight  (backlight),
    .rd_err     (rd_err),
    .timing_err (timing_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  bit     timing_on;
  int     short_n = 37;
  int     long_n  = 1520;

  // Reference LCD state, tracked at the level of transfers and bytes.
  bit         m_4bit, m_have_hi, m_inc, m_cg, m_bl;
  logic [3:0] m_hi;
  int         m_addr;
  longint     busy_until, last_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_4bit     = 1'b0;
    m_have_hi  = 1'b0;
    m_hi       = 4'h0;
    m_inc      = 1'b1;
    m_cg       = 1'b0;
    m_bl       = 1'b0;
    m_addr     = 0;
    busy_until = -1;
    last_done  = 0;
  endtask

  function automatic int step_addr(input int a, input bit inc);
    if (inc) return (a == 'h27) ? 'h40 : (a == 'h67) ? 0 : ((a + 1) & 'h7F);
    else     return (a == 0) ? 'h67 : (a == 'h40) ? 'h27 : ((a - 1) & 'h7F);
  endfunction

  task automatic apply_byte(input bit rs, input logic [7:0] b);
    int v;
    v = int'(b);
    if (rs) begin
      if (!m_cg) m_addr = step_addr(m_addr, m_inc);
    end else if (v == 1) begin
      m_addr = 0;
      m_inc  = 1'b1;
    end else if (v == 2 || v == 3) begin
      m_addr = 0;
    end else if (v >= 4 && v <= 7) begin
      m_inc = b[1];
    end else if (v >= 'h80) begin
      m_addr = v - 'h80;
      m_cg   = 1'b0;
    end else if (v >= 'h40) begin
      m_cg = 1'b1;
    end else if (v >= 'h20) begin
      m_4bit    = !b[4];
      m_have_hi = 1'b0;
    end
  endtask

  task automatic put(input logic [7:0] b);
    port_valid = 1'b1;
    port_byte  = b;
    m_bl       = b[3];
    @(posedge clk);
    #1;
    port_valid = 1'b0;
  endtask

  // Called one cycle after the EN-falling port write; cyc is that write's edge.
  task automatic strobe_check(input bit rs, input bit rw, input logic [3:0] nib);
    bit         done;
    bit         exp_terr;
    logic [7:0] byt;
    done     = 1'b0;
    byt      = 8'h00;
    exp_terr = timing_on && (cyc <= busy_until);
    if (rw) begin
      check("rd_err_pulse", 32'(rd_err), 32'd1);
    end else begin
      check("rd_err_quiet", 32'(rd_err), 32'd0);
      if (!m_4bit) begin
        byt  = {nib, 4'h0};
        done = 1'b1;
      end else if (!m_have_hi) begin
        m_have_hi = 1'b1;
        m_hi      = nib;
      end else begin
        byt       = {m_hi, nib};
        m_have_hi = 1'b0;
        done      = 1'b1;
      end
    end
    check("out_valid", 32'(out_valid), 32'(done));
    if (done) begin
      apply_byte(rs, byt);
      check("out_byte", 32'(out_byte), 32'(byt));
      check("out_rs", 32'(out_rs), 32'(rs));
      check("ddram_addr", 32'(ddram_addr), 32'(m_addr));
      last_done  = cyc;
      busy_until = cyc + ((!rs && (byt == 8'h01 || byt == 8'h02 || byt == 8'h03)) ? long_n : short_n);
    end
    check("mode4", 32'(mode4), 32'(m_4bit));
    check("timing_err", 32'(timing_err), 32'(exp_terr));
    check("backlight", 32'(backlight), 32'(m_bl));
  endtask

  task automatic send_nibble(input bit rs, input bit rw, input logic [3:0] nib, input int gap, input bit noise);
    logic [7:0] b;
    if (noise) begin
      put({4'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom)});
      check("noise_no_valid", 32'(out_valid), 32'd0);
      check("noise_no_rd", 32'(rd_err), 32'd0);
    end
    b = {nib, 1'($urandom), 1'b1, rw, rs};
    put(b);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    b[2] = 1'b0;
    put(b);
    strobe_check(rs, rw, nib);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b, input bit rd_inject);
    if (m_4bit) begin
      send_nibble(rs, 1'b0, b[7:4], $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      if (rd_inject) send_nibble(rs, 1'b1, 4'($urandom), $urandom_range(0, 2), 1'b0);
      send_nibble(rs, 1'b0, b[3:0], $urandom_range(0, 2), $urandom_range(0, 3) == 0);
    end else begin
      if (rd_inject) send_nibble(rs, 1'b1, 4'($urandom), $urandom_range(0, 2), 1'b0);
      send_nibble(rs, 1'b0, b[7:4], $urandom_range(0, 2), $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic strobe_at(input logic [3:0] nib, input longint target);
    while (cyc + 2 < target) begin
      @(posedge clk);
      #1;
    end
    send_nibble(1'b0, 1'b0, nib, 0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] init_nibs [10];
    int         hot [6];
    longint     c;
`ifdef HD44780_TIMING_CHECK_EN
    timing_on = 1'b1;
`else
    timing_on = 1'b0;
`endif
    init_nibs = '{4'h0, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    hot       = '{'h26, 'h27, 'h3F, 'h40, 'h66, 'h67};
    rst        = 1'b1;
    port_valid = 1'b0;
    port_byte  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_mode4", 32'(mode4), 32'd0);
    check("rst_ddram", 32'(ddram_addr), 32'd0);
    check("rst_timing_err", 32'(timing_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Power-up init stream, one nibble per EN pulse.
    for (int i = 0; i < 10; i++) send_nibble(1'b0, 1'b0, init_nibs[i], $urandom_range(0, 2), 1'b0);
    check("init_last_byte", 32'(out_byte), 32'h01);
    check("init_mode4", 32'(mode4), 32'd1);
    check("init_addr", 32'(ddram_addr), 32'd0);

    send_byte(1'b0, 8'h80, 1'b0);
    send_byte(1'b1, 8'h48, 1'b0);
    check("hi_H_addr", 32'(ddram_addr), 32'h01);
    send_byte(1'b1, 8'h69, 1'b0);
    check("hi_i_byte", 32'(out_byte), 32'h69);
    check("hi_i_addr", 32'(ddram_addr), 32'h02);

    send_byte(1'b0, 8'hA7, 1'b0);
    send_byte(1'b1, 8'h41, 1'b0);
    check("wrap_27_40", 32'(ddram_addr), 32'h40);
    send_byte(1'b0, 8'h80, 1'b0);
    send_byte(1'b0, 8'h04, 1'b0);
    send_byte(1'b1, 8'h42, 1'b0);
    check("wrap_00_67", 32'(ddram_addr), 32'h67);
    send_byte(1'b0, 8'h06, 1'b0);

    // Read strobe between the two halves must not disturb reassembly.
    send_nibble(1'b0, 1'b0, 4'hC, 0, 1'b0);
    send_nibble(1'b0, 1'b1, 4'h3, 0, 1'b0);
    check("rd_in_lo_no_valid", 32'(out_valid), 32'd0);
    send_nibble(1'b0, 1'b0, 4'h5, 0, 1'b0);
    check("rd_then_lo_byte", 32'(out_byte), 32'hC5);
    check("rd_then_lo_addr", 32'(ddram_addr), 32'h45);

`ifdef HD44780_TIMING_CHECK_EN
    send_byte(1'b0, 8'h01, 1'b0);
    c = last_done;
    strobe_at(4'h0, c + 1000);
    check("t_long_1000", 32'(timing_err), 32'd1);
    strobe_at(4'h6, c + 1600);
    check("t_long_1600", 32'(timing_err), 32'd0);
    c = last_done;
    strobe_at(4'h0, c + 30);
    check("t_short_30", 32'(timing_err), 32'd1);
    strobe_at(4'h6, c + 40);
    check("t_short_40", 32'(timing_err), 32'd0);
`else
    c = 0;
`endif

    // Reset in 4-bit mode with a high nibble pending.
    send_nibble(1'b0, 1'b0, 4'h8, 0, 1'b0);
    rst = 1'b1;
    #2;
    check("midrst_mode4", 32'(mode4), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_byte", 32'(out_byte), 32'd0);
    check("midrst_backlight", 32'(backlight), 32'd0);
    check("midrst_ddram", 32'(ddram_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    send_nibble(1'b0, 1'b0, 4'h3, 0, 1'b0);
    check("after_rst_byte", 32'(out_byte), 32'h30);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      bit         rs;
      int         k;
      rs = 1'b0;
      k  = $urandom_range(0, 9);
      case (k)
        0:       b = ($urandom_range(0, 1) == 1) ? 8'h28 : 8'h38;
        1:       b = 8'h04 | 8'($urandom_range(0, 3));
        2:       b = 8'h01 + 8'($urandom_range(0, 2));
        3:       b = 8'h80 | 8'(hot[$urandom_range(0, 5)]);
        4:       b = 8'h40 | 8'($urandom_range(0, 63));
        5:       b = 8'($urandom);
        default: begin
          rs = 1'b1;
          b  = 8'($urandom);
        end
      endcase
      send_byte(rs, b, $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
